// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divide unit.
// Build option DIV_SIGNED_EN (in div_seq_ctrl) enables signed operation.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    // Quotient returned for a zero divisor.
    localparam logic [DIV_WIDTH-1:0] DIV_DBZ_Q = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration on the concatenated {rem, quo} register.
// Purely combinational; the caller registers the result each cycle.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] rq,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] rq_next
);

    // Shifted remainder can reach WIDTH+1 bits when the divisor is near full scale.
    logic [WIDTH:0] rem_shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    assign rem_shifted = rq[2*WIDTH-1:WIDTH-1];
    assign diff        = rem_shifted - {1'b0, divisor};
    assign ge          = (rem_shifted >= {1'b0, divisor});

    assign rq_next = {(ge ? diff[WIDTH-1:0] : rem_shifted[WIDTH-1:0]),
                      rq[WIDTH-2:0], ge};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle 1-bit-per-cycle restoring divider with pipeline stall/flush handshake.
// Define DIV_SIGNED_EN to enable signed operation via the sign input.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] rq_reg, rq_step;
    logic [WIDTH-1:0]   divisor_reg;
    logic               busy_reg, done_reg;
    logic [WIDTH-1:0]   quotient_reg, remainder_reg;

    logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
    logic               accept;

`ifdef DIV_SIGNED_EN
    logic q_neg_reg, r_neg_reg;

    assign mag_a   = (sign && a[WIDTH-1]) ? -a : a;
    assign mag_b   = (sign && b[WIDTH-1]) ? -b : b;
    assign quo_fix = q_neg_reg ? -rq_step[WIDTH-1:0] : rq_step[WIDTH-1:0];
    assign rem_fix = r_neg_reg ? -rq_step[2*WIDTH-1:WIDTH] : rq_step[2*WIDTH-1:WIDTH];
`else
    logic unused_sign;

    assign unused_sign = sign;
    assign mag_a       = a;
    assign mag_b       = b;
    assign quo_fix     = rq_step[WIDTH-1:0];
    assign rem_fix     = rq_step[2*WIDTH-1:WIDTH];
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rq      (rq_reg),
        .divisor (divisor_reg),
        .rq_next (rq_step)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !flush) begin
                    accept     = 1'b1;
                    state_next = (b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_reg == CNT_W'(WIDTH-1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Flush overrides everything, including a final iteration.
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rq_reg        <= '0;
            divisor_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
`ifdef DIV_SIGNED_EN
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == DONE);
            if (accept) begin
                rq_reg      <= {{WIDTH{1'b0}}, mag_a};
                divisor_reg <= mag_b;
                cnt_reg     <= '0;
`ifdef DIV_SIGNED_EN
                q_neg_reg   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_reg   <= sign & a[WIDTH-1];
`endif
                if (b == '0) begin
                    quotient_reg  <= {WIDTH{1'b1}};
                    remainder_reg <= a;
                end
            end else if (state_reg == CALC) begin
                rq_reg  <= rq_step;
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (state_next == DONE) begin
                    quotient_reg  <= quo_fix;
                    remainder_reg <= rem_fix;
                end
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign stall     = (start && (state_reg == IDLE) && !flush) || (state_reg == CALC);

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Multi-cycle sequencer for the CPU's 32-bit divide unit. Accepts one divide request from the EX stage, iterates a radix-2 restoring divide step one bit per cycle, and applies sign correction for signed operations. Returns quotient and remainder with a one-cycle `done` pulse. Sits between the EX stage and the hazard unit, driving `stall` so the pipeline holds while the division runs.

## Interface
Parameters:
- `WIDTH`, 32: operand, quotient and remainder width.
- `CNT_W`, 6: iteration counter width; must hold `WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `sign`  in  1  1 = signed divide, 0 = unsigned.
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `a`  in  WIDTH  dividend; captured at accepted `start`.
- `b`  in  WIDTH  divisor; captured at accepted `start`.
- `busy`  out  1  registered; high in CALC and DONE.
- `stall`  out  1  combinational: `(start & idle & ~flush) | calc`.
- `done`  out  1  registered; one-cycle pulse when results become valid.
- `quotient`  out  WIDTH  registered result.
- `remainder`  out  WIDTH  registered result.

## Operation
- States:
  - IDLE: waits for a request.
    - `start & ~flush`: latch magnitudes of `a` and `b` (two's-complement absolute value if `sign`, else raw).
    - Also latch `q_neg = sign & (a[W-1] ^ b[W-1])` and `r_neg = sign & a[W-1]`.
    - If `b == 0`, go to DONE; otherwise clear the counter and go to CALC.
  - CALC: each cycle, shift the {rem, quo} register left by 1. If `rem_shifted >= |b|`, subtract and set the quotient LSB. Increment the counter. After iteration `WIDTH` (counter = WIDTH-1), go to DONE.
  - DONE: `done` = 1 for exactly this cycle, then go to IDLE.
- Result loading (on the edge entering DONE):
  - `quotient = q_neg ? -quo : quo`.
  - `remainder = r_neg ? -rem : rem`.
- Divide by zero: `quotient = {WIDTH{1'b1}}`, `remainder = a` (original value, unmodified), regardless of `sign`.
- Signed overflow (INT_MIN / -1): the magnitude arithmetic naturally yields quotient 0x80000000 and remainder 0. No special case.
- Results hold their values until the next entry into DONE.
- `start` while not in IDLE is ignored. It is not queued.
- `flush` in any state returns the FSM to IDLE on the next edge.
  - `done` is not pulsed.
  - `quotient` and `remainder` keep their previous values.
  - `flush` with `start` in the same IDLE cycle: flush wins and the request is dropped.
- Reset (asynchronous, any time):
  - FSM goes to IDLE; counter and working registers go to 0.
  - `busy`, `done`, `quotient` and `remainder` go to 0.

## Timing
- Accepted `start` at edge T0:
  - CALC occupies cycles T0+1 through T0+WIDTH.
  - `done` is high in cycle T0+WIDTH+1 (cycle 33 for WIDTH = 32).
- Divide by zero: `done` is high in cycle T0+1.
- `stall` is high from the `start` cycle through the last CALC cycle. It is low in the DONE cycle, so EX consumes the results there.
- A new `start` is accepted one cycle after DONE, at the earliest. Back-to-back throughput is 1 op per WIDTH+2 cycles.

## Configuration
- `DIV_SIGNED_EN`:
  - Defined: signed support as described above.
  - Undefined: the `sign` input is ignored and treated as 0. The absolute-value, negation and `q_neg`/`r_neg` logic is not compiled. All operations are unsigned with identical latency.

## Structure
- Package `div_pkg`:
  - State enum `div_state_t` {IDLE, CALC, DONE}.
  - Constants `DIV_WIDTH` = 32 and `DIV_CNT_W` = 6.
  - The divide-by-zero quotient constant.
- Sub-module `div_step`: purely combinational single restoring iteration.
  - Inputs: {rem, quo}, divisor.
  - Outputs: next {rem, quo}.
  - Instantiated once inside the CALC datapath.

## Test plan
- Unsigned 100 / 7, `start` at T0 → `done` at T0+33, quotient 14, remainder 2. `stall` is high T0 through T0+32.
- Signed -7 / 2 (`a` = 0xFFFFFFF9, `b` = 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Without `DIV_SIGNED_EN` → quotient 0x7FFFFFFC, remainder 1.
- Divide by zero 5 / 0 → `done` at T0+1, quotient 0xFFFFFFFF, remainder 5, `stall` high only in the T0 cycle.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- `flush` in cycle T0+10 → no `done`, FSM in IDLE at T0+11, outputs unchanged. A following 9 / 3 returns quotient 3, remainder 0.
- `rst_n` low mid-CALC → all outputs 0 immediately. Subsequent 0xFFFFFFFF / 0x10 returns quotient 0x0FFFFFFF, remainder 0xF. A `start` pulsed during CALC of that operation has no effect.
